// File: rtl/exec_pkg.sv
// Shared types for the execute-to-writeback pipeline: op codes, default
// geometry and the default-width stage payload layout.
package exec_pkg;

    localparam int W_DEF     = 16;
    localparam int LANES_DEF = 4;
    localparam int RW_DEF    = 4;
    localparam int PC_W      = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_PASS = 3'd3,
        OP_NOP  = 3'd4
    } op_e;

    // Field order used by every stage register; the top redeclares it at its own widths.
    typedef struct packed {
        logic [PC_W-1:0]            pc;
        logic                       vec;
        logic                       wen;
        logic [RW_DEF-1:0]          rt;
        logic                       halt;
        logic [LANES_DEF*W_DEF-1:0] result;
    } stage_pay_t;

endpackage

// File: rtl/exec_lane_alu.sv
// Single-lane combinational ALU; a disabled lane (scalar op, lane > 0) yields 0.
module exec_lane_alu
    import exec_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [2:0]   op,
    input  logic         laneEn,
    input  logic [W-1:0] ra,
    input  logic [W-1:0] rx,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        if (laneEn) begin
            case (op)
                OP_ADD:  result = ra + rx;
                OP_SUB:  result = rx - ra;
                OP_MUL:  result = ra * rx;
                OP_PASS: result = ra;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/exec_wb_pipeline.sv
// Execute-to-writeback pipeline: ALU on entry, STAGES registered stages,
// valid/ready output to writeback, flush, sticky halt and in-flight rt query.
module exec_wb_pipeline
    import exec_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int W      = W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int RW     = RW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  in_pc,
    input  logic [2:0]                   in_op,
    input  logic                         in_vec,
    input  logic                         in_wen,
    input  logic [RW-1:0]                in_rt,
    input  logic                         in_halt,
    input  logic [LANES*W-1:0]           in_ra_val,
    input  logic [LANES*W-1:0]           in_rx_val,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [15:0]                  wb_pc,
    output logic                         wb_vec,
    output logic                         wb_wen,
    output logic [RW-1:0]                wb_rt,
    output logic                         wb_halt,
    output logic [LANES*W-1:0]           wb_result,
    input  logic                         flush,
    input  logic [RW-1:0]                chk_reg,
    output logic                         chk_hit,
    output logic                         halted,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    typedef struct packed {
        logic [15:0]          pc;
        logic                 vec;
        logic                 wen;
        logic [RW-1:0]        rt;
        logic                 halt;
        logic [LANES*W-1:0]   result;
    } payload_t;

    logic [STAGES-1:0] stageValid;
    payload_t          stagePay [STAGES];
    payload_t          newPay;
    logic              lastValid;
    logic              advance;
    logic              accept;
    logic [LANES*W-1:0] aluResult;

    // Handshake: a transfer happens on an edge where valid && ready are both high.
    // Input side: in_ready only when the chain can shift, not halted and not flushing.
    // Output side: wb_valid is the last stage's valid masked by flush; the whole
    // chain shifts whenever the last stage is empty or writeback takes it.
    assign lastValid = stageValid[STAGES-1];
    assign advance   = !lastValid || wb_ready;
    assign in_ready  = advance && !halted && !flush;
    assign accept    = in_valid && in_ready;
    assign wb_valid  = lastValid && !flush;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        exec_lane_alu #(.W(W)) u_alu (
            .op     (in_op),
            .laneEn (l == 0 || in_vec),
            .ra     (in_ra_val[l*W +: W]),
            .rx     (in_rx_val[l*W +: W]),
            .result (aluResult[l*W +: W])
        );
    end

    always_comb begin
        newPay        = '0;
        newPay.pc     = in_pc;
        newPay.vec    = in_vec;
        newPay.wen    = in_wen;
        newPay.rt     = in_rt;
        newPay.halt   = in_halt;
        newPay.result = aluResult;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic     nextValid;
        payload_t nextPay;

        if (s == 0) begin : g_head
            assign nextValid = accept;
            assign nextPay   = newPay;
        end else begin : g_body
            assign nextValid = stageValid[s-1];
            assign nextPay   = stagePay[s-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stageValid[s] <= 1'b0;
            end else if (flush) begin
                stageValid[s] <= 1'b0;
            end else if (advance) begin
                stageValid[s] <= nextValid;
            end
        end

        // Payload is meaningless while the matching valid is low, so it carries no reset.
        always_ff @(posedge clk) begin
            if (advance && !flush) begin
                stagePay[s] <= nextPay;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (wb_valid && wb_ready && stagePay[STAGES-1].halt) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        chk_hit   = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            occupancy = occupancy + OCC_W'(stageValid[s]);
            chk_hit   = chk_hit | (stageValid[s] && stagePay[s].wen && (stagePay[s].rt == chk_reg));
        end
    end

    assign wb_pc     = stagePay[STAGES-1].pc;
    assign wb_vec    = stagePay[STAGES-1].vec;
    assign wb_wen    = stagePay[STAGES-1].wen;
    assign wb_rt     = stagePay[STAGES-1].rt;
    assign wb_halt   = stagePay[STAGES-1].halt;
    assign wb_result = stagePay[STAGES-1].result;

endmodule

// File: tb/tb_exec_wb_pipeline.sv
// Directed bench for exec_wb_pipeline at STAGES=2, LANES=4, W=16, RW=4.
module tb_exec_wb_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [2:0]  in_op;
    logic        in_vec;
    logic        in_wen;
    logic [3:0]  in_rt;
    logic        in_halt;
    logic [63:0] in_ra_val;
    logic [63:0] in_rx_val;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_pc;
    logic        wb_vec;
    logic        wb_wen;
    logic [3:0]  wb_rt;
    logic        wb_halt;
    logic [63:0] wb_result;
    logic        flush;
    logic [3:0]  chk_reg;
    logic        chk_hit;
    logic        halted;
    logic [1:0]  occupancy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] st_pc  [6];
    logic [2:0]  st_op  [6];
    logic        st_vec [6];
    logic [63:0] st_ra  [6];
    logic [63:0] st_rx  [6];
    logic [63:0] st_exp [6];

    exec_wb_pipeline #(.STAGES(2), .W(16), .LANES(4), .RW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_op     (in_op),
        .in_vec    (in_vec),
        .in_wen    (in_wen),
        .in_rt     (in_rt),
        .in_halt   (in_halt),
        .in_ra_val (in_ra_val),
        .in_rx_val (in_rx_val),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_pc     (wb_pc),
        .wb_vec    (wb_vec),
        .wb_wen    (wb_wen),
        .wb_rt     (wb_rt),
        .wb_halt   (wb_halt),
        .wb_result (wb_result),
        .flush     (flush),
        .chk_reg   (chk_reg),
        .chk_hit   (chk_hit),
        .halted    (halted),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc, input logic [2:0] op, input logic vec,
                         input logic wen, input logic [3:0] rt, input logic halt,
                         input logic [63:0] ra, input logic [63:0] rx);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_op     = op;
        in_vec    = vec;
        in_wen    = wen;
        in_rt     = rt;
        in_halt   = halt;
        in_ra_val = ra;
        in_rx_val = rx;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b1; flush = 1'b0; chk_reg = 4'd0;
        drive(16'h0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0, 64'h0, 64'h0);
        in_valid = 1'b0;
        tick(); tick();
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid); else pass_cnt++;
        total_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else pass_cnt++;
        total_cnt++; if (chk_hit !== 1'b0) $display("FAIL reset_chk_hit: got %b want 0", chk_hit); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        st_pc[0] = 16'h10; st_op[0] = 3'd0; st_vec[0] = 1'b1;
        st_ra[0] = 64'h0004_0003_0002_0001; st_rx[0] = 64'h0028_001E_0014_000A; st_exp[0] = 64'h002C_0021_0016_000B;
        st_pc[1] = 16'h12; st_op[1] = 3'd1; st_vec[1] = 1'b0;
        st_ra[1] = 64'h1111_2222_3333_0005; st_rx[1] = 64'h0009_0008_0007_0003; st_exp[1] = 64'h0000_0000_0000_FFFE;
        st_pc[2] = 16'h14; st_op[2] = 3'd2; st_vec[2] = 1'b1;
        st_ra[2] = 64'hFFFF_0100_0004_0003; st_rx[2] = 64'h0002_0100_0006_0005; st_exp[2] = 64'hFFFE_0000_0018_000F;
        st_pc[3] = 16'h16; st_op[3] = 3'd3; st_vec[3] = 1'b0;
        st_ra[3] = 64'hAAAA_BBBB_CCCC_1234; st_rx[3] = 64'h5555_5555_5555_5555; st_exp[3] = 64'h0000_0000_0000_1234;
        st_pc[4] = 16'h18; st_op[4] = 3'd7; st_vec[4] = 1'b1;
        st_ra[4] = 64'h0001_0001_0001_0001; st_rx[4] = 64'h0002_0002_0002_0002; st_exp[4] = 64'h0;
        st_pc[5] = 16'h1A; st_op[5] = 3'd1; st_vec[5] = 1'b1;
        st_ra[5] = 64'h0001_0001_0005_0002; st_rx[5] = 64'h0000_0003_0005_0007; st_exp[5] = 64'hFFFF_0002_0000_0005;
        wb_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c < 6) drive(st_pc[c], st_op[c], st_vec[c], 1'b0, 4'd0, 1'b0, st_ra[c], st_rx[c]);
            else in_valid = 1'b0;
            tick();
            if (c == 0) begin
                total_cnt++; if (wb_valid !== 1'b0) $display("FAIL stream_latency: wb_valid %b after one edge, want 0", wb_valid); else pass_cnt++;
            end else begin
                total_cnt++; if (wb_valid !== 1'b1 || wb_pc !== st_pc[c-1])
                    $display("FAIL stream_pc[%0d]: valid %b pc %h, want 1 pc %h", c-1, wb_valid, wb_pc, st_pc[c-1]); else pass_cnt++;
                total_cnt++; if (wb_result !== st_exp[c-1] || wb_vec !== st_vec[c-1])
                    $display("FAIL stream_result[%0d]: got %h vec %b, want %h vec %b", c-1, wb_result, wb_vec, st_exp[c-1], st_vec[c-1]); else pass_cnt++;
            end
        end
        tick();
        total_cnt++; if (wb_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL stream_drain: valid %b occ %0d, want 0 0", wb_valid, occupancy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        drive(16'h30, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h1, 64'h1);
        tick();
        drive(16'h32, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h2, 64'h2);
        tick();
        drive(16'h34, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h3, 64'h3);
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (in_ready !== 1'b0 || occupancy !== 2'd2 || wb_pc !== 16'h30 || wb_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: rdy %b occ %0d pc %h valid %b, want 0 2 0030 1", i, in_ready, occupancy, wb_pc, wb_valid); else pass_cnt++;
            tick();
        end
        wb_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_pc !== 16'h32 || occupancy !== 2'd2 || wb_result !== 64'h4)
            $display("FAIL bp_retire1: valid %b pc %h occ %0d res %h, want 1 0032 2 4", wb_valid, wb_pc, occupancy, wb_result); else pass_cnt++;
        tick();
        total_cnt++; if (wb_valid !== 1'b1 || wb_pc !== 16'h34 || occupancy !== 2'd1 || wb_result !== 64'h6)
            $display("FAIL bp_retire2: valid %b pc %h occ %0d res %h, want 1 0034 1 6", wb_valid, wb_pc, occupancy, wb_result); else pass_cnt++;
        tick();
        total_cnt++; if (wb_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL bp_no_dup: valid %b occ %0d, want 0 0", wb_valid, occupancy); else pass_cnt++;
    endtask

    task automatic test_flush();
        wb_ready = 1'b1;
        drive(16'h40, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h1, 64'h1);
        tick();
        drive(16'h42, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h1, 64'h1);
        tick();
        drive(16'h44, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h1, 64'h1);
        flush = 1'b1;
        #1;
        total_cnt++; if (wb_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL flush_mask: valid %b rdy %b, want 0 0", wb_valid, in_ready); else pass_cnt++;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        total_cnt++; if (occupancy !== 2'd0 || wb_valid !== 1'b0)
            $display("FAIL flush_clear: occ %0d valid %b, want 0 0", occupancy, wb_valid); else pass_cnt++;
        tick();
        total_cnt++; if (occupancy !== 2'd0 || wb_valid !== 1'b0)
            $display("FAIL flush_no_accept: occ %0d valid %b, want 0 0", occupancy, wb_valid); else pass_cnt++;
    endtask

    task automatic test_hazard();
        wb_ready = 1'b1;
        chk_reg = 4'd7;
        drive(16'h50, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0, 64'h1, 64'h1);
        #1;
        total_cnt++; if (chk_hit !== 1'b0) $display("FAIL hz_input_ignored: got %b want 0", chk_hit); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (chk_hit !== 1'b1) $display("FAIL hz_stage0: got %b want 1", chk_hit); else pass_cnt++;
        tick();
        total_cnt++; if (chk_hit !== 1'b1 || wb_valid !== 1'b1 || wb_rt !== 4'd7 || wb_wen !== 1'b1)
            $display("FAIL hz_stage1: hit %b valid %b rt %0d wen %b, want 1 1 7 1", chk_hit, wb_valid, wb_rt, wb_wen); else pass_cnt++;
        tick();
        total_cnt++; if (chk_hit !== 1'b0) $display("FAIL hz_retired: got %b want 0", chk_hit); else pass_cnt++;
        drive(16'h52, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0, 64'h1, 64'h1);
        tick();
        in_valid = 1'b0;
        chk_reg = 4'd6;
        #1;
        total_cnt++; if (chk_hit !== 1'b0) $display("FAIL hz_other_reg: got %b want 0", chk_hit); else pass_cnt++;
        chk_reg = 4'd7;
        #1;
        total_cnt++; if (chk_hit !== 1'b1) $display("FAIL hz_same_reg: got %b want 1", chk_hit); else pass_cnt++;
        tick(); tick();
        drive(16'h54, 3'd0, 1'b0, 1'b0, 4'd7, 1'b0, 64'h1, 64'h1);
        tick();
        in_valid = 1'b0;
        total_cnt++; if (chk_hit !== 1'b0) $display("FAIL hz_no_wen: got %b want 0", chk_hit); else pass_cnt++;
        tick(); tick();
    endtask

    task automatic test_halt();
        wb_ready = 1'b1;
        drive(16'h20, 3'd4, 1'b0, 1'b0, 4'd0, 1'b1, 64'h0, 64'h0);
        tick();
        drive(16'h22, 3'd0, 1'b0, 1'b1, 4'd2, 1'b0, 64'h5, 64'h6);
        tick();
        in_valid = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_pc !== 16'h20 || wb_halt !== 1'b1 || halted !== 1'b0)
            $display("FAIL halt_at_wb: valid %b pc %h halt %b halted %b, want 1 0020 1 0", wb_valid, wb_pc, wb_halt, halted); else pass_cnt++;
        tick();
        total_cnt++; if (halted !== 1'b1 || wb_valid !== 1'b1 || wb_pc !== 16'h22 || wb_result !== 64'hB)
            $display("FAIL halt_drain: halted %b valid %b pc %h res %h, want 1 1 0022 b", halted, wb_valid, wb_pc, wb_result); else pass_cnt++;
        drive(16'h24, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h1, 64'h1);
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL halt_ready: got %b want 0", in_ready); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (in_ready !== 1'b0 || wb_valid !== 1'b0 || occupancy !== 2'd0 || halted !== 1'b1)
            $display("FAIL halt_sticky: rdy %b valid %b occ %0d halted %b, want 0 0 0 1", in_ready, wb_valid, occupancy, halted); else pass_cnt++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
        tick();
        rst = 1'b0;
        wb_ready = 1'b0;
        drive(16'h60, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h1, 64'h1);
        tick();
        drive(16'h62, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 64'h1, 64'h1);
        tick();
        in_valid = 1'b0;
        total_cnt++; if (occupancy !== 2'd2 || wb_valid !== 1'b1)
            $display("FAIL rst_prefill: occ %0d valid %b, want 2 1", occupancy, wb_valid); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (occupancy !== 2'd0 || wb_valid !== 1'b0 || halted !== 1'b0)
            $display("FAIL rst_async: occ %0d valid %b halted %b, want 0 0 0", occupancy, wb_valid, halted); else pass_cnt++;
        wb_ready = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL rst_no_pulse: got %b want 0", wb_valid); else pass_cnt++;
        drive(16'h70, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002);
        tick();
        in_valid = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL rst_latency_early: got %b want 0", wb_valid); else pass_cnt++;
        tick();
        total_cnt++; if (wb_valid !== 1'b1 || wb_pc !== 16'h70 || wb_result !== 64'h0003_0003_0003_0003)
            $display("FAIL rst_latency: valid %b pc %h res %h, want 1 0070 0003000300030003", wb_valid, wb_pc, wb_result); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hazard();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/exec_wb_pipeline.md
Name: exec_wb_pipeline

Overview:
- Parametrised execute-to-writeback pipeline for the scalar/vector core.
- Accepts one decoded op per cycle with operand values already read.
- Computes a per-lane ALU result on entry, carries the op through STAGES registered execute stages, and presents it to writeback under a valid/ready handshake.
- Generalises the fixed two-stage execute chain:
  - configurable depth, data width and vector lane count;
  - global stall, flush and sticky halt;
  - an in-flight destination-register hit query for hazard detection in decode.

Parameters:
- STAGES, 2, number of registered execute stages (≥1); accept-to-wb_valid latency in cycles.
- W, 16, lane data width in bits.
- LANES, 4, vector lanes; scalar ops use lane 0 only.
- RW, 4, register index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  pipeline accepts this cycle.
- in_pc  in  16  op PC.
- in_op  in  3  op code: ADD=0, SUB=1, MUL=2, PASS=3, NOP=4; 5–7 act as NOP.
- in_vec  in  1  vector op, all lanes active.
- in_wen  in  1  op writes register rt.
- in_rt  in  RW  destination register.
- in_halt  in  1  halt instruction.
- in_ra_val  in  LANES*W  ra operand, lane i at bits [i*W +: W].
- in_rx_val  in  LANES*W  rx operand.
- wb_valid  out  1  result available at writeback.
- wb_ready  in  1  writeback consumes this cycle.
- wb_pc  out  16  PC.
- wb_vec  out  1  vector flag.
- wb_wen  out  1  write enable.
- wb_rt  out  RW  destination.
- wb_halt  out  1  halt flag.
- wb_result  out  LANES*W  result.
- flush  in  1  kill all in-flight ops.
- chk_reg  in  RW  register queried by decode.
- chk_hit  out  1  some in-flight valid op has wen && rt==chk_reg.
- halted  out  1  sticky; halt has retired.
- occupancy  out  $clog2(STAGES+1)  count of valid stages.

Behaviour:
- Reset values (async, immediate): all stage valids 0, halted 0, occupancy 0, wb_valid 0, chk_hit 0. Payload registers may be left unreset; the wb_* payload outputs are don't-care while wb_valid=0.
- Advance:
  - advance = !last_valid || wb_ready.
  - When advance=1, every stage shifts one forward and stage 0 loads the input.
  - When advance=0, all stages hold. A held stage never loses or duplicates its op.
- Handshake:
  - in_ready = advance && !halted && !flush.
  - Stage 0 loads a valid op only when in_valid && in_ready; otherwise it loads a bubble.
  - wb_valid = last_valid && !flush.
  - An op transfers out when wb_valid && wb_ready.
- Latency: an op accepted at edge k has wb_valid=1 after edge k+STAGES-1 (i.e., during the cycle after STAGES edges), given no stall.
- Throughput: one op per cycle with wb_ready held high.
- ALU, computed at stage 0 load, per lane, modulo 2^W:
  - ADD: ra+rx.
  - SUB: rx−ra.
  - MUL: low W bits of ra*rx.
  - PASS: ra.
  - NOP: 0.
  - Scalar (in_vec=0): lanes 1..LANES−1 of the result are forced to 0.
- Flush:
  - Combinationally masks wb_valid and in_ready.
  - At the next edge, all stage valids clear, including the last stage; nothing is accepted that cycle.
  - Flush has priority over stall and input.
  - Flush does not clear halted.
- Halt:
  - When an op with wb_halt transfers out, halted sets at that edge and stays set until rst.
  - While halted, in_ready=0.
  - Ops already in flight behind the halt still drain to writeback.
- chk_hit: OR over all valid stages of (wen && rt==chk_reg), computed from registered state only; the in_* inputs do not contribute. It is 0 for flushed or invalid stages.
- occupancy: number of valid stage registers, updated at each edge.
- Simultaneous accept and retire with a full pipeline: allowed; occupancy stays unchanged.
- rst asserted mid-operation: all in-flight ops are lost immediately; no wb_valid pulse follows.

Decomposition:
- Shared package exec_pkg:
  - op enum (ADD, SUB, MUL, PASS, NOP);
  - default W, LANES and RW;
  - packed stage payload struct {pc, vec, wen, rt, halt, result}.
- One natural sub-module: exec_lane_alu, a single-lane W-bit combinational ALU, instantiated LANES times.
- Stage registers are a generate loop over STAGES.

Test Plan:
- Stream, STAGES=2, LANES=4, W=16, wb_ready=1: vector ADD, ra lanes {1,2,3,4}, rx lanes {10,20,30,40} → after 2 cycles wb_valid=1, wb_result lanes {11,22,33,44}. Follow with scalar SUB ra=5, rx=3 → lane0=0xFFFE, lanes 1–3 = 0.
- Backpressure: issue 3 ops back-to-back, hold wb_ready=0 for 4 cycles → in_ready=0 once full, occupancy=2, wb_pc stable. Release → ops retire in order with no loss or duplicate.
- Flush: 2 ops in flight plus in_valid=1 with flush=1 for one cycle → wb_valid=0 that cycle, occupancy=0 next cycle, the input op is not accepted.
- Halt: HALT at pc=0x20 followed by ADD at pc=0x22 → halted rises at the edge where pc 0x20 transfers out, pc 0x22 still retires, in_ready stays 0 afterwards.
- Hazard: op with wen=1, rt=7 in flight and chk_reg=7 → chk_hit=1 each cycle until it retires, then 0. chk_reg=6 → chk_hit=0. Op with wen=0, rt=7 → chk_hit=0.
- Reset mid-stream: assert rst with 2 valid stages → wb_valid and occupancy drop to 0 immediately, halted=0. Deassert rst → next op has latency 2.
